// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port among N_REQ requesters.
// Registers the winning command onto the RAM port and returns ID-tagged read data after the read latency.
module ram_port_arbiter #(
    parameter int N_REQ        = 4,
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 18,
    parameter int READ_LATENCY = 2,
    parameter int ID_W         = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_din,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    ram_en,
    output logic                    ram_we,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       ram_din,
    output logic                    ram_regce,
    output logic                    ram_rst,
    input  logic [DATA_W-1:0]       ram_dout,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_data
);
    // One extra bit so ranks and the pointer arithmetic never wrap.
    localparam int RW = ID_W + 1;

    logic [ID_W-1:0]   ptr_reg;
    logic [RW-1:0]     rank [N_REQ];
    logic [ADDR_W-1:0] addr_slice [N_REQ];
    logic [DATA_W-1:0] din_slice [N_REQ];

    logic [N_REQ-1:0]  grant_vec;
    logic [ID_W-1:0]   grant_idx;
    logic [RW-1:0]     best_rank;
    logic              transfer;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_din;

    logic              ram_en_reg;
    logic              ram_we_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [DATA_W-1:0] ram_din_reg;
    logic [ID_W-1:0]   cmd_id_reg;

    logic [READ_LATENCY-1:0] rd_valid_reg;
    logic [READ_LATENCY-1:0] rd_valid_next;
    logic [ID_W-1:0]         rd_id_reg  [READ_LATENCY];
    logic [ID_W-1:0]         rd_id_next [READ_LATENCY];

    genvar gi;

    // rank = distance of requester gi after the pointer (0 = highest priority).
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign addr_slice[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign din_slice[gi]  = req_din[gi*DATA_W +: DATA_W];
            assign rank[gi] = (RW'(gi) > {1'b0, ptr_reg})
                            ? RW'(gi) - {1'b0, ptr_reg} - RW'(1)
                            : RW'(gi + N_REQ) - {1'b0, ptr_reg} - RW'(1);
        end
    endgenerate

    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        best_rank = '1;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && (rank[i] < best_rank)) begin
                best_rank    = rank[i];
                grant_idx    = ID_W'(i);
                grant_vec    = '0;
                grant_vec[i] = 1'b1;
            end
        end
    end

    assign req_ready = rst_n ? grant_vec : '0;
    assign transfer  = |req_ready;

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_din  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_vec[i]) begin
                sel_we   = req_we[i];
                sel_addr = addr_slice[i];
                sel_din  = din_slice[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg      <= ID_W'(N_REQ - 1);
            ram_en_reg   <= 1'b0;
            ram_we_reg   <= 1'b0;
            ram_addr_reg <= '0;
            ram_din_reg  <= '0;
            cmd_id_reg   <= '0;
        end else begin
            ram_en_reg <= transfer;
            ram_we_reg <= transfer & sel_we;
            if (transfer) begin
                ptr_reg      <= grant_idx;
                ram_addr_reg <= sel_addr;
                ram_din_reg  <= sel_din;
                cmd_id_reg   <= grant_idx;
            end
        end
    end

    assign ram_en   = ram_en_reg;
    assign ram_we   = ram_we_reg;
    assign ram_addr = ram_addr_reg;
    assign ram_din  = ram_din_reg;
    assign ram_rst  = ~rst_n;

    // Read-tracking shift pipeline: stage 0 is loaded from the cycle the RAM sees the read.
    generate
        for (gi = 0; gi < READ_LATENCY; gi++) begin : g_rd
            if (gi == 0) begin : g_head
                assign rd_valid_next[gi] = ram_en_reg & ~ram_we_reg;
                assign rd_id_next[gi]    = cmd_id_reg;
            end else begin : g_tail
                assign rd_valid_next[gi] = rd_valid_reg[gi-1];
                assign rd_id_next[gi]    = rd_id_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_reg <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_id_reg[i] <= '0;
            end
        end else begin
            rd_valid_reg <= rd_valid_next;
            rd_id_reg    <= rd_id_next;
        end
    end

    // The output register must capture in the cycle before the response is presented.
    generate
        if (READ_LATENCY >= 2) begin : g_regce
            assign ram_regce = rd_valid_reg[READ_LATENCY-2];
        end else begin : g_no_regce
            assign ram_regce = 1'b0;
        end
    endgenerate

    assign rsp_valid = rd_valid_reg[READ_LATENCY-1];
    assign rsp_id    = rd_id_reg[READ_LATENCY-1];
    assign rsp_data  = rsp_valid ? ram_dout : '0;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Round-robin arbiter that shares one port of a single-clock block RAM among N_REQ requesters. Each requester issues read or write commands over a valid/ready handshake. The arbiter drives the RAM port's enable, write enable, address, data, output-register enable and output reset. It tracks read latency and returns each read's data tagged with the originating requester ID. One instance sits in front of each shared RAM port.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 10, RAM address width
DATA_W, 18, RAM data width
READ_LATENCY, 2, RAM read latency in cycles after ram_en (1 = no output register, 2 = output register)
ID_W, 2, requester ID width; must be at least clog2(N_REQ)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous reset, active-low
req_valid  in  N_REQ  per-requester command valid
req_we  in  N_REQ  per-requester write (1) / read (0)
req_addr  in  N_REQ*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
req_din  in  N_REQ*DATA_W  flattened write data
req_ready  out  N_REQ  one-hot grant; a command transfers when valid & ready
ram_en  out  1  RAM port enable
ram_we  out  1  RAM port write enable
ram_addr  out  ADDR_W  RAM port address
ram_din  out  DATA_W  RAM port write data
ram_regce  out  1  RAM output register enable
ram_rst  out  1  RAM output register reset (active-high)
ram_dout  in  DATA_W  RAM port read data
rsp_valid  out  1  read response valid, single-cycle pulse
rsp_id  out  ID_W  requester that issued the read
rsp_data  out  DATA_W  read data

Behaviour:
- Reset (rst_n=0 at a clk edge): ram_en, ram_we, ram_regce, rsp_valid, req_ready are 0; ram_addr, ram_din, rsp_id, rsp_data are 0; latency pipeline is cleared; round-robin pointer is N_REQ-1, so requester 0 has top priority first.
- ram_rst = ~rst_n, a combinational passthrough.
- Grant (combinational): search from pointer+1 upward, wrapping modulo N_REQ, for the first set req_valid bit. req_ready is one-hot on that requester and all-zero when no requester is valid or rst_n=0.
- At most one grant per cycle. The pointer updates to the granted index on each transfer and holds otherwise.
- A requester that is not selected waits while holding valid. A requester valid continuously gets no more than every N_REQ-th grant when all requesters are active.
- Command stage (registered): on a transfer, the next cycle has ram_en=1, ram_we=req_we[g], ram_addr/ram_din = the granted slice. With no transfer, ram_en=0 and ram_we=0; address and data hold.
- Throughput: one command per cycle, back-to-back, with no bubbles.
- Read tracking: a shift pipeline of depth READ_LATENCY carries {valid = ram_en & ~ram_we, id}.
- READ_LATENCY=2: ram_regce = stage-1 valid (one cycle after the ram_en read cycle).
- READ_LATENCY=1: ram_regce is 0.
- Response: rsp_valid/rsp_id rise at the end of the pipeline. rsp_data = ram_dout in that same cycle (combinational capture, no extra register).
- Total latency is 1 + READ_LATENCY cycles from the read handshake to rsp_valid.
- Writes produce no response. Write-first data appearing on ram_dout during a write is ignored.
- Responses have no backpressure; requesters must always accept them. Responses return in issue order.
- Address collision, i.e. a read and a write to the same address in consecutive cycles: RAM ordering holds, and the read issued after the write returns the new data.
- Reset mid-operation: in-flight reads are discarded with no rsp_valid, and the pointer returns to N_REQ-1.
- Deasserting req_valid without a handshake is permitted and simply withdraws the request.

Test Plan:
1. Reset, then requester 0 writes addr 0x005 data 0x2A5A5 and then reads addr 0x005 -> ram_en/ram_we=1 one cycle after the write handshake; rsp_valid with id 0 and data 0x2A5A5 arrives 3 cycles after the read handshake (READ_LATENCY=2).
2. All four requesters hold valid reads to addrs 0x010..0x013 -> grants go 0,1,2,3 on consecutive cycles; responses return ids 0,1,2,3 with their stored data, back-to-back.
3. Requesters 1 and 3 valid continuously, last grant was 1 -> grants alternate 3,1,3,1; neither is starved.
4. Read of addr 0x020 in flight, rst_n driven 0 for 1 cycle -> no rsp_valid; ram_rst=1 during that cycle; the next grant goes to requester 0 when all are valid.
5. READ_LATENCY=1 build: read handshake at cycle t -> rsp_valid at t+2; ram_regce stays 0.
6. Interleaved write 0x033=0x1FFFF (req 2) then read 0x033 (req 0) on back-to-back cycles -> read returns 0x1FFFF with id 0; the write produces no rsp_valid.
